// File: rtl/regfile_wb_sb.sv
// regfile_wb_sb: MIPS GPR file with two combinational read ports, one
// write-back port with load formatting (lb/lbu/lh/lhu/lw/lui), optional
// write-to-read bypass and a per-register busy scoreboard for long loads.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   rs_addr/rs_data      read port A (index in, data out, combinational)
//   rt_addr/rt_data      read port B
//   stall                a read source is busy and not resolved this cycle
//   iss_valid/iss_dst    long-latency issue, marks iss_dst busy
//   wb_valid/wb_dst      write-back request and destination
//   wb_fmt/wb_lo/wb_data load format, byte offset, raw data
//   busy_cnt             registered count of busy registers
module regfile_wb_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              stall,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_dst,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_dst,
    input  logic [2:0]        wb_fmt,
    input  logic [1:0]        wb_lo,
    input  logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] rf_q [DEPTH];
    logic [DATA_W-1:0] rf_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [ADDR_W:0]   busy_cnt_q;
    logic [ADDR_W:0]   busy_cnt_d;

    logic              wb_en;
    logic              iss_en;
    logic              byp_rs;
    logic              byp_rt;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] fmtd;

    // Ports are inert while reset is held, so nothing is forwarded or latched.
    assign wb_en  = wb_valid && !rst;
    assign iss_en = iss_valid && !rst;

    always_comb begin
        byte_sel = wb_data[{wb_lo, 3'b000} +: 8];
        half_sel = wb_lo[1] ? wb_data[31:16] : wb_data[15:0];
        case (wb_fmt)
            3'd1:    fmtd = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            3'd2:    fmtd = {{(DATA_W-8){1'b0}}, byte_sel};
            3'd3:    fmtd = {{(DATA_W-16){half_sel[15]}}, half_sel};
            3'd4:    fmtd = {{(DATA_W-16){1'b0}}, half_sel};
            3'd5:    fmtd = {wb_data[15:0], {(DATA_W-16){1'b0}}};
            default: fmtd = wb_data;
        endcase
    end

    assign byp_rs = (BYPASS != 0) && wb_en && (wb_dst == rs_addr);
    assign byp_rt = (BYPASS != 0) && wb_en && (wb_dst == rt_addr);

    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (rs_addr != '0) rs_data = byp_rs ? fmtd : rf_q[rs_addr];
        if (rt_addr != '0) rt_data = byp_rt ? fmtd : rf_q[rt_addr];
    end

    // busy_q[0] is held at 0, so index 0 can never stall.
    assign stall = (busy_q[rs_addr] && !byp_rs) ||
                   (busy_q[rt_addr] && !byp_rt);

    always_comb begin
        rf_d = rf_q;
        if (wb_en && wb_dst != '0) rf_d[wb_dst] = fmtd;
    end

    // Clear first, then set: a new producer issued in the same cycle wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_en)  busy_d[wb_dst]  = 1'b0;
        if (iss_en) busy_d[iss_dst] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++)
            busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            rf_q       <= rf_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_wb_sb.sv
// tb_regfile_wb_sb: scoreboard bench for regfile_wb_sb, one instance with
// bypass and one without, both driven by the same directed+random stimulus.
module tb_regfile_wb_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs_addr, rt_addr, iss_dst, wb_dst;
    logic        iss_valid, wb_valid;
    logic [2:0]  wb_fmt;
    logic [1:0]  wb_lo;
    logic [31:0] wb_data;

    logic [31:0] rs1, rt1, rs0, rt0;
    logic        st1, st0;
    logic [5:0]  cnt1, cnt0;

    always #5 clk = ~clk;

    regfile_wb_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs1), .rt_data(rt1), .stall(st1),
        .iss_valid(iss_valid), .iss_dst(iss_dst),
        .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_fmt(wb_fmt),
        .wb_lo(wb_lo), .wb_data(wb_data), .busy_cnt(cnt1)
    );

    regfile_wb_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs0), .rt_data(rt0), .stall(st0),
        .iss_valid(iss_valid), .iss_dst(iss_dst),
        .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_fmt(wb_fmt),
        .wb_lo(wb_lo), .wb_data(wb_data), .busy_cnt(cnt0)
    );

    typedef struct {
        logic [31:0] rs1, rt1, rs0, rt0;
        logic        st1, st0;
        logic [5:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: architectural register values and busy set.
    logic [31:0] m_rf [32];
    bit          m_busy [32];

    function automatic logic [31:0] fmt_model(input logic [2:0] f,
                                              input logic [1:0] lo,
                                              input logic [31:0] d);
        logic [31:0] b, h;
        b = (d >> (8 * lo)) & 32'hFF;
        h = lo[1] ? (d >> 16) : (d & 32'hFFFF);
        case (f)
            3'd1: return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
            3'd2: return b;
            3'd3: return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
            3'd4: return h;
            3'd5: return (d & 32'hFFFF) * 32'h10000;
            default: return d;
        endcase
    endfunction

    function automatic int busy_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += m_busy[i];
        return n;
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        logic [31:0] v;
        logic br, bt;
        v  = fmt_model(wb_fmt, wb_lo, wb_data);
        br = wb_valid && wb_dst == rs_addr;
        bt = wb_valid && wb_dst == rt_addr;
        e.rs0 = (rs_addr == 0) ? 32'h0 : m_rf[rs_addr];
        e.rt0 = (rt_addr == 0) ? 32'h0 : m_rf[rt_addr];
        e.rs1 = (rs_addr != 0 && br) ? v : e.rs0;
        e.rt1 = (rt_addr != 0 && bt) ? v : e.rt0;
        e.st0 = (rs_addr != 0 && m_busy[rs_addr]) ||
                (rt_addr != 0 && m_busy[rt_addr]);
        e.st1 = (rs_addr != 0 && m_busy[rs_addr] && !br) ||
                (rt_addr != 0 && m_busy[rt_addr] && !bt);
        e.cnt = 6'(busy_count());
        if (rst) begin
            e.rs1 = 0; e.rt1 = 0; e.rs0 = 0; e.rt0 = 0;
            e.st1 = 0; e.st0 = 0; e.cnt = 0;
        end
        return e;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_rf[i]   = 0;
            m_busy[i] = 0;
        end
    endtask

    task automatic model_edge();
        if (rst) return;
        if (wb_valid && wb_dst != 0)
            m_rf[wb_dst] = fmt_model(wb_fmt, wb_lo, wb_data);
        if (wb_valid) m_busy[wb_dst] = 0;
        if (iss_valid && iss_dst != 0) m_busy[iss_dst] = 1;
    endtask

    // One cycle: drive at posedge+1, queue expectation, advance the model.
    task automatic drive(input logic [4:0] ra, input logic [4:0] rb,
                         input logic iv, input logic [4:0] id,
                         input logic wv, input logic [4:0] wd,
                         input logic [2:0] f, input logic [1:0] lo,
                         input logic [31:0] d);
        rs_addr = ra; rt_addr = rb;
        iss_valid = iv; iss_dst = id;
        wb_valid = wv; wb_dst = wd; wb_fmt = f; wb_lo = lo; wb_data = d;
        exp_q.push_back(expect_now());
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rs_byp",  rs1, e.rs1);
            chk("rt_byp",  rt1, e.rt1);
            chk("stall_byp", {31'b0, st1}, {31'b0, e.st1});
            chk("cnt_byp", {26'b0, cnt1}, {26'b0, e.cnt});
            chk("rs_nobyp", rs0, e.rs0);
            chk("rt_nobyp", rt0, e.rt0);
            chk("stall_nobyp", {31'b0, st0}, {31'b0, e.st0});
            chk("cnt_nobyp", {26'b0, cnt0}, {26'b0, e.cnt});
        end
    end

    initial begin
        rst = 1'b1;
        rs_addr = 0; rt_addr = 0; iss_valid = 0; iss_dst = 0;
        wb_valid = 0; wb_dst = 0; wb_fmt = 0; wb_lo = 0; wb_data = 0;
        model_clear();
        @(posedge clk); #1;
        // Reset state, with a write attempted while reset is held.
        drive(5, 6, 1, 7, 1, 5, 0, 0, 32'h1111);
        rst = 1'b0;
        drive(5, 7, 0, 0, 0, 0, 0, 0, 0);

        // Load r5 and mark r7 busy, then assert reset mid-cycle.
        drive(0, 0, 1, 7, 1, 5, 0, 0, 32'h1234);
        drive(5, 7, 0, 0, 0, 0, 0, 0, 0);
        rs_addr = 5; rt_addr = 7;
        iss_valid = 1; iss_dst = 9;
        wb_valid = 1; wb_dst = 6; wb_fmt = 0; wb_lo = 0; wb_data = 32'h55;
        #1 rst = 1'b1;
        model_clear();
        exp_q.push_back(expect_now());
        @(posedge clk);
        #1 rst = 1'b0;
        drive(6, 9, 0, 0, 0, 0, 0, 0, 0);

        // Load formatting.
        drive(0, 0, 0, 0, 1, 2, 1, 1, 32'h80FF7F01);
        drive(2, 0, 0, 0, 1, 3, 1, 3, 32'h80FF7F01);
        drive(3, 2, 0, 0, 1, 4, 2, 3, 32'h80FF7F01);
        drive(4, 3, 0, 0, 1, 6, 3, 2, 32'h80FF7F01);
        drive(6, 4, 0, 0, 1, 7, 4, 2, 32'h80FF7F01);
        drive(7, 6, 0, 0, 1, 8, 5, 1, 32'h80FF7F01);
        drive(8, 7, 0, 0, 1, 31, 6, 0, 32'h00400008);
        drive(31, 8, 0, 0, 0, 0, 0, 0, 0);

        // Register 0 is never written nor busy.
        drive(0, 0, 0, 0, 1, 0, 0, 0, 32'hDEADBEEF);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Same-cycle bypass.
        drive(9, 0, 0, 0, 1, 9, 0, 0, 32'hCAFEF00D);
        drive(9, 0, 0, 0, 0, 0, 0, 0, 0);

        // Scoreboard issue, stall, write-back release.
        drive(0, 0, 1, 10, 0, 0, 0, 0, 0);
        drive(10, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(10, 0, 0, 0, 1, 10, 0, 0, 32'h0BADCAFE);
        drive(10, 10, 0, 0, 0, 0, 0, 0, 0);

        // Simultaneous issue and write-back to one index.
        drive(0, 0, 1, 12, 1, 12, 0, 0, 32'h12121212);
        drive(12, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 12, 0, 0, 1, 12, 0, 0, 32'h34343434);
        drive(12, 0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic, biased to a few indices so collisions happen.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] ra, rb, id, wd;
            ra = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
            rb = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
            id = 5'($urandom_range(0, 6));
            wd = 5'($urandom_range(0, 6));
            drive(ra, rb, $urandom_range(0, 2) == 0, id,
                  $urandom_range(0, 1) == 0, wd,
                  3'($urandom), 2'($urandom), $urandom);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
